activation: RTL and testbench
=============================

// Module: activation
// PURPOSE
//  Parametrised neuron activation unit: forward pass maps signed fixed-point argument to unsigned
//  activation (sigmoid LUT or clipped ReLU); in training, backward pass scales incoming error by
//  activation derivative and propagates it. Sits between a neuron's weighted-sum accumulator and
//  the next layer; valid/ready handshakes on all four streams.
// PARAMETERS
//  ARG_WIDTH  16  signed argument width, FRAC fractional bits
//  FRAC       8   argument fractional bits
//  RES_WIDTH  8   unsigned result width, value = result/2**RES_WIDTH
//  ERR_WIDTH  16  signed error/propagate width, FRAC fractional bits
//  LUT_BITS   12  sigmoid LUT address bits; linear range [-2**(LUT_BITS-1), 2**(LUT_BITS-1)) LSBs
//  FUNC       0   0 = sigmoid, 1 = clipped ReLU
// PORTS
//  clock            in   1          rising-edge clock
//  reset            in   1          asynchronous, active-high reset
//  train            in   1          sampled at result handshake; 1 = run backward pass
//  argument_valid   in   1          argument stream
//  argument_data    in   ARG_WIDTH  signed argument
//  argument_ready   out  1
//  result_valid     out  1          activation stream
//  result_data      out  RES_WIDTH  activation
//  result_ready     in   1
//  error_valid      in   1          error stream from downstream
//  error_data       in   ERR_WIDTH  signed error
//  error_ready      out  1
//  propagate_valid  out  1          propagated error upstream
//  propagate_data   out  ERR_WIDTH  signed error*derivative
//  propagate_ready  in   1
// BEHAVIOUR
//  Reset (async, any state): state=ARG; result_valid=propagate_valid=0; result_data, propagate_data,
//   stored result, derivative = 0. Held until reset deasserts.
//  FSM ARG->RES on argument handshake; RES->ERR if train else ARG on result handshake;
//   ERR->PRP on error handshake; PRP->ARG on propagate handshake. Unused encoding -> ARG.
//  argument_ready = (state==ARG); error_ready = (state==ERR); combinational from state only.
//  Forward: argument handshake at edge n registers result_data and sets result_valid=1 at same edge
//   (visible cycle n+1). result_data stable while result_valid && !result_ready; result_valid
//   clears on the handshake edge. No new argument accepted until then.
//  Sigmoid: L=2**(LUT_BITS-1). arg>=L -> 2**RES_WIDTH-1; arg<-L -> 0; else
//   LUT[arg[LUT_BITS-1:0]] = min(floor(2**RES_WIDTH/(1+exp(-arg/2**FRAC))), 2**RES_WIDTH-1).
//  ReLU: arg<=0 -> 0; arg >= 2**FRAC -> 2**RES_WIDTH-1; else arg scaled by 2**(RES_WIDTH-FRAC).
//  Derivative (RES_WIDTH+1 bits, unsigned), computed from stored result r:
//   sigmoid d = (r*(2**RES_WIDTH-r)) >> RES_WIDTH; ReLU d = 2**RES_WIDTH if 0<r<max else 0.
//  Backward: error handshake at edge m latches error; propagate_data = (error*$signed({0,d}))
//   >>> RES_WIDTH (arithmetic, truncate toward -inf), width ERR_WIDTH, cannot overflow; registered
//   and propagate_valid=1 at edge m+1. propagate_data stable until handshake; propagate_valid
//   clears on the handshake edge (no stuck valid).
//  train changes outside result handshake have no effect on the current transaction.
//  Back-to-back inference (train=0): one result per 2 cycles minimum with ready held high.
//  Reset mid-transaction aborts it; no partial output after reset release.
// TESTING
//  FUNC=0: arg 0x0000 -> 0x80; 0x0100 -> 0xBB; 0x0800 -> 0xFF; 0xF800 -> 0x00; 0x7FFF -> 0xFF.
//  FUNC=0 train=1: arg 0x0000, error 0x0100 -> propagate 0x0040; error 0xFF00 -> 0xFFC0.
//  FUNC=1 train=1: arg 0x0040 -> result 0x40, error 0x0200 -> propagate 0x0200;
//   arg 0xFF00 -> result 0x00, propagate 0x0000.
//  Backpressure: result_ready low 5 cycles -> result_data stable, argument_ready=0, valid held;
//   same for propagate_ready low.
//  train=0 stream of 4 args with ready high -> 4 results, error_ready never asserted.
//  Reset asserted mid-PRP, async (between edges) -> propagate_valid=0 immediately, argument_ready=1.

Source files
------------

// File: rtl/activation.sv
// Neuron activation unit: forward pass maps a signed fixed-point argument to a sigmoid or
// clipped-ReLU activation; in training the backward pass scales the returning error by the derivative.
module activation #(
  parameter int ARG_WIDTH = 16,
  parameter int FRAC      = 8,
  parameter int RES_WIDTH = 8,
  parameter int ERR_WIDTH = 16,
  parameter int LUT_BITS  = 12,
  parameter int FUNC      = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        train,
  input  logic                        argument_valid,
  input  logic signed [ARG_WIDTH-1:0] argument_data,
  output logic                        argument_ready,
  output logic                        result_valid,
  output logic        [RES_WIDTH-1:0] result_data,
  input  logic                        result_ready,
  input  logic                        error_valid,
  input  logic signed [ERR_WIDTH-1:0] error_data,
  output logic                        error_ready,
  output logic                        propagate_valid,
  output logic signed [ERR_WIDTH-1:0] propagate_data,
  input  logic                        propagate_ready
);

  localparam logic [RES_WIDTH-1:0] RES_MAX    = '1;
  localparam logic [RES_WIDTH:0]   DERIV_ONE  = {1'b1, {RES_WIDTH{1'b0}}};
  localparam int                   PROD_WIDTH = ERR_WIDTH + RES_WIDTH + 2;

  typedef enum logic [1:0] {
    ST_ARG,
    ST_RES,
    ST_ERR,
    ST_PRP
  } state_t;

  state_t state;
  state_t state_next;

  logic                        arg_fire;
  logic                        res_fire;
  logic                        err_fire;
  logic                        prp_fire;
  logic        [RES_WIDTH-1:0] act_value;
  logic        [RES_WIDTH:0]   act_deriv;
  logic        [RES_WIDTH:0]   derivative;
  logic signed [ERR_WIDTH-1:0] error_reg;
  logic signed [PROD_WIDTH-1:0] error_product;
  logic signed [ERR_WIDTH-1:0] propagate_next;

  // One sigmoid table entry; the table address is the argument's low bits read as two's complement.
  function automatic logic [RES_WIDTH-1:0] sigmoid_entry(input int index);
    int  centred;
    real scaled;
    int  value;
    centred = (index >= 2**(LUT_BITS-1)) ? index - 2**LUT_BITS : index;
    scaled  = (2.0 ** RES_WIDTH) / (1.0 + $exp(-real'(centred) / (2.0 ** FRAC)));
    value   = $rtoi(scaled);
    if (value > 2**RES_WIDTH - 1) value = 2**RES_WIDTH - 1;
    return RES_WIDTH'(value);
  endfunction

  assign arg_fire = argument_valid && argument_ready;
  assign res_fire = result_valid && result_ready;
  assign err_fire = error_valid && error_ready;
  assign prp_fire = propagate_valid && propagate_ready;

  generate
    if (FUNC == 0) begin : g_sigmoid
      localparam int LUT_DEPTH = 2**LUT_BITS;
      localparam logic signed [ARG_WIDTH-1:0] LIN_HI = ARG_WIDTH'(2**(LUT_BITS-1));
      localparam logic signed [ARG_WIDTH-1:0] LIN_LO = -LIN_HI;

      logic [RES_WIDTH-1:0]   lut [LUT_DEPTH];
      logic [2*RES_WIDTH+1:0] deriv_product;

      for (genvar i = 0; i < LUT_DEPTH; i++) begin : g_entry
        assign lut[i] = sigmoid_entry(i);
      end

      always_comb begin
        act_value = lut[argument_data[LUT_BITS-1:0]];
        if (argument_data >= LIN_HI) begin
          act_value = RES_MAX;
        end else if (argument_data < LIN_LO) begin
          act_value = '0;
        end
      end

      // r*(1-r) in result units, using the freshly computed activation
      assign deriv_product = (2*RES_WIDTH+2)'(act_value) *
                             (2*RES_WIDTH+2)'(DERIV_ONE - {1'b0, act_value});
      assign act_deriv     = (RES_WIDTH+1)'(deriv_product >> RES_WIDTH);
    end else begin : g_relu
      localparam logic signed [ARG_WIDTH-1:0] ARG_ONE = ARG_WIDTH'(2**FRAC);

      always_comb begin
        act_value = RES_WIDTH'({argument_data, {RES_WIDTH{1'b0}}} >> FRAC);
        if (argument_data[ARG_WIDTH-1] || argument_data == '0) begin
          act_value = '0;
        end else if (argument_data >= ARG_ONE) begin
          act_value = RES_MAX;
        end
      end

      assign act_deriv = (act_value != '0 && act_value != RES_MAX) ? DERIV_ONE : '0;
    end
  endgenerate

  assign error_product  = $signed({{(PROD_WIDTH-ERR_WIDTH){error_reg[ERR_WIDTH-1]}}, error_reg}) *
                          $signed({{(PROD_WIDTH-RES_WIDTH-1){1'b0}}, derivative});
  assign propagate_next = ERR_WIDTH'(error_product >>> RES_WIDTH);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_ARG;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    argument_ready = 1'b0;
    error_ready    = 1'b0;
    case (state)
      ST_ARG: begin
        argument_ready = 1'b1;
        if (argument_valid) state_next = ST_RES;
      end
      ST_RES: begin
        if (res_fire) state_next = train ? ST_ERR : ST_ARG;
      end
      ST_ERR: begin
        error_ready = 1'b1;
        if (error_valid) state_next = ST_PRP;
      end
      ST_PRP: begin
        if (prp_fire) state_next = ST_ARG;
      end
      default: state_next = ST_ARG;
    endcase
  end

  // Result and derivative are captured together so the backward pass uses the delivered activation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_valid    <= 1'b0;
      result_data     <= '0;
      derivative      <= '0;
      error_reg       <= '0;
      propagate_valid <= 1'b0;
      propagate_data  <= '0;
    end else begin
      if (arg_fire) begin
        result_data  <= act_value;
        derivative   <= act_deriv;
        result_valid <= 1'b1;
      end else if (res_fire) begin
        result_valid <= 1'b0;
      end

      if (err_fire) error_reg <= error_data;

      if (state == ST_PRP && !propagate_valid) begin
        propagate_data  <= propagate_next;
        propagate_valid <= 1'b1;
      end else if (prp_fire) begin
        propagate_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_activation.sv
// Bench for activation: a sigmoid instance and a ReLU instance checked against a transaction-level
// model every cycle, plus directed vectors with hand-computed values.
module tb_activation;

  localparam int N = 2;

  localparam logic [15:0] SIG_ARGS [9] = '{16'h0000, 16'h0100, 16'h0800, 16'hF800, 16'h7FFF,
                                           16'h8000, 16'hFF00, 16'h07FF, 16'h0200};
  localparam logic [7:0]  SIG_LITS [9] = '{8'h80, 8'hBB, 8'hFF, 8'h00, 8'hFF,
                                           8'h00, 8'h44, 8'hFF, 8'hE1};
  localparam logic [15:0] RELU_ARGS [8] = '{16'h0040, 16'hFF00, 16'h0100, 16'h00FF,
                                            16'h0001, 16'h0000, 16'h7FFF, 16'h8000};
  localparam logic [7:0]  RELU_LITS [8] = '{8'h40, 8'h00, 8'hFF, 8'hFF,
                                            8'h01, 8'h00, 8'hFF, 8'h00};
  localparam logic [15:0] STREAM_ARGS [4] = '{16'h0200, 16'hFF00, 16'h8000, 16'h0010};

  logic        clock = 1'b0;
  logic        reset;
  logic        train           [N];
  logic        argument_valid  [N];
  logic [15:0] argument_data   [N];
  logic        argument_ready  [N];
  logic        result_valid    [N];
  logic [7:0]  result_data     [N];
  logic        result_ready    [N];
  logic        error_valid     [N];
  logic [15:0] error_data      [N];
  logic        error_ready     [N];
  logic        propagate_valid [N];
  logic [15:0] propagate_data  [N];
  logic        propagate_ready [N];

  int errors = 0;
  int checks = 0;
  int cycle_count = 0;

  // Model state, owned by the compare process
  logic        res_pending  [N];
  logic        busy         [N];
  logic        want_err     [N];
  logic        prop_wait    [N];
  logic        prop_pending [N];
  logic [7:0]  exp_res      [N];
  logic [7:0]  exp_r        [N];
  logic [15:0] exp_prop     [N];
  int          res_count    [N];
  int          err_ready_count [N];

  always #5 clock = ~clock;

  always @(posedge clock) cycle_count <= cycle_count + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    activation #(.FUNC(g)) dut (
      .clock           (clock),
      .reset           (reset),
      .train           (train[g]),
      .argument_valid  (argument_valid[g]),
      .argument_data   (argument_data[g]),
      .argument_ready  (argument_ready[g]),
      .result_valid    (result_valid[g]),
      .result_data     (result_data[g]),
      .result_ready    (result_ready[g]),
      .error_valid     (error_valid[g]),
      .error_data      (error_data[g]),
      .error_ready     (error_ready[g]),
      .propagate_valid (propagate_valid[g]),
      .propagate_data  (propagate_data[g]),
      .propagate_ready (propagate_ready[g])
    );
  end

  function automatic int model_act(input int func, input int arg);
    real y;
    int  v;
    if (func == 0) begin
      if (arg >= 2048) return 255;
      if (arg < -2048) return 0;
      y = 256.0 / (1.0 + $exp(-real'(arg) / 256.0));
      v = $rtoi(y);
      return (v > 255) ? 255 : v;
    end
    if (arg <= 0) return 0;
    if (arg >= 256) return 255;
    return arg;
  endfunction

  function automatic int model_deriv(input int func, input int r);
    if (func == 0) return (r * (256 - r)) / 256;
    return (r > 0 && r < 255) ? 256 : 0;
  endfunction

  function automatic int model_prop(input int err, input int d);
    return $rtoi($floor(real'(err * d) / 256.0));
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Outputs are sampled on the falling edge; handshakes seen there are the ones the next rising edge takes.
  always @(negedge clock) begin
    for (int k = 0; k < N; k++) begin
      if (reset) begin
        res_pending[k]  = 1'b0;
        busy[k]         = 1'b0;
        want_err[k]     = 1'b0;
        prop_wait[k]    = 1'b0;
        prop_pending[k] = 1'b0;
        exp_res[k]      = '0;
        exp_r[k]        = '0;
        exp_prop[k]     = '0;
      end else begin
        check_output($sformatf("cmp%0d result_valid", k), 64'(result_valid[k]), 64'(res_pending[k]));
        if (res_pending[k])
          check_output($sformatf("cmp%0d result_data", k), 64'(result_data[k]), 64'(exp_res[k]));
        check_output($sformatf("cmp%0d argument_ready", k), 64'(argument_ready[k]), 64'(!busy[k]));
        check_output($sformatf("cmp%0d error_ready", k), 64'(error_ready[k]), 64'(want_err[k]));
        check_output($sformatf("cmp%0d propagate_valid", k), 64'(propagate_valid[k]), 64'(prop_pending[k]));
        if (prop_pending[k])
          check_output($sformatf("cmp%0d propagate_data", k), 64'(propagate_data[k]), 64'(exp_prop[k]));
        if (error_ready[k]) err_ready_count[k]++;

        if (prop_wait[k]) begin
          prop_wait[k]    = 1'b0;
          prop_pending[k] = 1'b1;
        end
        if (argument_valid[k] && argument_ready[k]) begin
          exp_res[k]     = 8'(model_act(k, int'($signed(argument_data[k]))));
          res_pending[k] = 1'b1;
          busy[k]        = 1'b1;
        end
        if (result_valid[k] && result_ready[k]) begin
          res_pending[k] = 1'b0;
          res_count[k]++;
          exp_r[k] = exp_res[k];
          if (train[k]) want_err[k] = 1'b1;
          else          busy[k]     = 1'b0;
        end
        if (error_valid[k] && error_ready[k]) begin
          exp_prop[k]  = 16'(model_prop(int'($signed(error_data[k])), model_deriv(k, int'(exp_r[k]))));
          prop_wait[k] = 1'b1;
          want_err[k]  = 1'b0;
        end
        if (propagate_valid[k] && propagate_ready[k]) begin
          prop_pending[k] = 1'b0;
          busy[k]         = 1'b0;
        end
      end
    end
  end

  task automatic apply_stimulus(input int k, input logic [15:0] arg, input logic tr);
    logic ok;
    ok = 1'b0;
    train[k]          = tr;
    argument_data[k]  = arg;
    argument_valid[k] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (argument_ready[k]) begin
        ok = 1'b1;
        break;
      end
    end
    check_output($sformatf("arg_accept%0d", k), 64'(ok), 64'(1));
    tick();
    argument_valid[k] = 1'b0;
  endtask

  task automatic forward(input int k, input logic [15:0] arg, input logic tr, input logic [7:0] lit,
                         input int hold, input string name);
    logic ok;
    ok = 1'b0;
    apply_stimulus(k, arg, tr);
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (result_valid[k]) begin
        ok = 1'b1;
        break;
      end
    end
    check_output({name, " result_wait"}, 64'(ok), 64'(1));
    check_output({name, " result"}, 64'(result_data[k]), 64'(lit));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check_output({name, " held_result"}, 64'(result_data[k]), 64'(lit));
      check_output({name, " held_valid"}, 64'(result_valid[k]), 64'(1));
      check_output({name, " held_arg_ready"}, 64'(argument_ready[k]), 64'(0));
    end
    tick();
    result_ready[k] = 1'b1;
    tick();
    result_ready[k] = 1'b0;
    train[k]        = 1'b0;
  endtask

  task automatic backward(input int k, input logic [15:0] err, input logic [15:0] lit,
                          input int hold, input string name);
    logic ok;
    ok = 1'b0;
    error_data[k]  = err;
    error_valid[k] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (error_ready[k]) begin
        ok = 1'b1;
        break;
      end
    end
    check_output({name, " err_accept"}, 64'(ok), 64'(1));
    tick();
    error_valid[k] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (propagate_valid[k]) begin
        ok = 1'b1;
        break;
      end
    end
    check_output({name, " prop_wait"}, 64'(ok), 64'(1));
    check_output({name, " propagate"}, 64'(propagate_data[k]), 64'(lit));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check_output({name, " held_prop"}, 64'(propagate_data[k]), 64'(lit));
      check_output({name, " held_prop_valid"}, 64'(propagate_valid[k]), 64'(1));
      check_output({name, " held_arg_ready"}, 64'(argument_ready[k]), 64'(0));
    end
    tick();
    propagate_ready[k] = 1'b1;
    tick();
    propagate_ready[k] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start_cycle;
    int base_res;
    int base_err;
    logic ok;

    reset = 1'b1;
    for (int k = 0; k < N; k++) begin
      train[k]           = 1'b0;
      argument_valid[k]  = 1'b0;
      argument_data[k]   = '0;
      result_ready[k]    = 1'b0;
      error_valid[k]     = 1'b0;
      error_data[k]      = '0;
      propagate_ready[k] = 1'b0;
    end
    repeat (3) tick();
    @(negedge clock);
    for (int k = 0; k < N; k++) begin
      check_output($sformatf("reset%0d result_valid", k), 64'(result_valid[k]), 64'(0));
      check_output($sformatf("reset%0d propagate_valid", k), 64'(propagate_valid[k]), 64'(0));
      check_output($sformatf("reset%0d argument_ready", k), 64'(argument_ready[k]), 64'(1));
      check_output($sformatf("reset%0d error_ready", k), 64'(error_ready[k]), 64'(0));
      check_output($sformatf("reset%0d result_data", k), 64'(result_data[k]), 64'(0));
      check_output($sformatf("reset%0d propagate_data", k), 64'(propagate_data[k]), 64'(0));
    end
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] sigmoid forward vectors");
    for (int i = 0; i < 9; i++)
      forward(0, SIG_ARGS[i], 1'b0, SIG_LITS[i], 0, $sformatf("sig_fwd[%0d]", i));

    $display("[TB] relu forward vectors");
    for (int i = 0; i < 8; i++)
      forward(1, RELU_ARGS[i], 1'b0, RELU_LITS[i], 0, $sformatf("relu_fwd[%0d]", i));

    $display("[TB] training passes with backpressure");
    forward(0, 16'h0000, 1'b1, 8'h80, 5, "sig_bp");
    backward(0, 16'h0100, 16'h0040, 5, "sig_bp");
    forward(0, 16'h0000, 1'b1, 8'h80, 0, "sig_neg");
    backward(0, 16'hFF00, 16'hFFC0, 0, "sig_neg");
    forward(0, 16'h0100, 1'b1, 8'hBB, 0, "sig_floor");
    backward(0, 16'hFFFD, 16'hFFFF, 0, "sig_floor");
    forward(0, 16'h0800, 1'b1, 8'hFF, 0, "sig_sat");
    backward(0, 16'h7FFF, 16'h0000, 0, "sig_sat");
    forward(1, 16'h0040, 1'b1, 8'h40, 0, "relu_lin");
    backward(1, 16'h0200, 16'h0200, 0, "relu_lin");
    forward(1, 16'hFF00, 1'b1, 8'h00, 0, "relu_zero");
    backward(1, 16'h0123, 16'h0000, 0, "relu_zero");
    forward(1, 16'h0080, 1'b1, 8'h80, 0, "relu_negerr");
    backward(1, 16'hFE01, 16'hFE01, 0, "relu_negerr");

    $display("[TB] back-to-back inference stream");
    result_ready[0]   = 1'b1;
    train[0]          = 1'b0;
    start_cycle       = cycle_count;
    base_res          = res_count[0];
    base_err          = err_ready_count[0];
    argument_valid[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      argument_data[0] = STREAM_ARGS[i];
      ok = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clock);
        if (argument_ready[0]) begin
          ok = 1'b1;
          break;
        end
      end
      check_output($sformatf("stream accept[%0d]", i), 64'(ok), 64'(1));
      tick();
    end
    argument_valid[0] = 1'b0;
    check_output("stream rate", 64'((cycle_count - start_cycle) <= 8), 64'(1));
    tick();
    tick();
    result_ready[0] = 1'b0;
    check_output("stream results", 64'(res_count[0] - base_res), 64'(4));
    check_output("stream error_ready", 64'(err_ready_count[0] - base_err), 64'(0));

    $display("[TB] asynchronous reset during propagate");
    forward(1, 16'h0040, 1'b1, 8'h40, 0, "relu_pre_reset");
    error_data[1]  = 16'h0100;
    error_valid[1] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (error_ready[1]) begin
        ok = 1'b1;
        break;
      end
    end
    check_output("mid_reset err_accept", 64'(ok), 64'(1));
    tick();
    error_valid[1] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (propagate_valid[1]) begin
        ok = 1'b1;
        break;
      end
    end
    check_output("mid_reset prop_wait", 64'(ok), 64'(1));
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_output("mid_reset propagate_valid", 64'(propagate_valid[1]), 64'(0));
    check_output("mid_reset argument_ready", 64'(argument_ready[1]), 64'(1));
    check_output("mid_reset result_valid", 64'(result_valid[1]), 64'(0));
    check_output("mid_reset propagate_data", 64'(propagate_data[1]), 64'(0));
    tick();
    reset = 1'b0;
    tick();
    @(negedge clock);
    check_output("post_reset propagate_valid", 64'(propagate_valid[1]), 64'(0));
    check_output("post_reset error_ready", 64'(error_ready[1]), 64'(0));
    tick();
    forward(1, 16'h0080, 1'b0, 8'h80, 0, "relu_post_reset");
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
